// File: rtl/feature_store_writer_pkg.sv
// rtl/feature_store_writer_pkg.sv - shared word/layer constants, layer codes and code decoder (optional FEATURE_STORE_ERR_EN)
package feature_store_writer_pkg;

   localparam int DATA_LEN_DEF     = 8;
   localparam int ADDR_W_DEF       = 8;
   localparam int LAYER_STRIDE_DEF = 32;
   localparam int PHASE_STRIDE_DEF = 4;
   localparam int WORDS_PER_VEC    = 36;
   localparam int WORDS_PER_BEAT   = 9;

   localparam logic [3:0] LAYER0 = 4'd0;
   localparam logic [3:0] LAYER1 = 4'd1;
   localparam logic [3:0] LAYER2 = 4'd2;
   localparam logic [3:0] LAYER3 = 4'd3;
   localparam logic [3:0] AFFINE = 4'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_DONE
   } wr_state_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] index;
   } layer_sel_t;

   // Unknown codes fall back to region 0 with valid cleared
   function automatic layer_sel_t decode_layer(input logic [3:0] cs);
      layer_sel_t r;
      r.valid = 1'b1;
      r.index = 3'd0;
      case (cs)
         LAYER0:  r.index = 3'd0;
         LAYER1:  r.index = 3'd1;
         LAYER2:  r.index = 3'd2;
         LAYER3:  r.index = 3'd3;
         AFFINE:  r.index = 3'd4;
         default: begin
            r.valid = 1'b0;
            r.index = 3'd0;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/feature_store_writer_if.sv
// rtl/feature_store_writer_if.sv - request and RAM write bus of the feature store writer (err exists with FEATURE_STORE_ERR_EN)
interface feature_store_writer_if
   import feature_store_writer_pkg::*;
#(
   parameter int DATA_LEN = DATA_LEN_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
);
   logic                                start;
   logic [3:0]                          cs;
   logic [2:0]                          phase;
   logic [WORDS_PER_VEC*DATA_LEN-1:0]   d;
   logic                                ready;
   logic                                ram_we;
   logic [ADDR_W-1:0]                   ram_addr;
   logic [WORDS_PER_BEAT*DATA_LEN-1:0]  ram_d;
   logic                                done;
`ifdef FEATURE_STORE_ERR_EN
   logic                                err;
`endif

   modport master (
      output start, cs, phase, d,
      input  ready, ram_we, ram_addr, ram_d, done
`ifdef FEATURE_STORE_ERR_EN
      , input err
`endif
   );

   modport slave (
      input  start, cs, phase, d,
      output ready, ram_we, ram_addr, ram_d, done
`ifdef FEATURE_STORE_ERR_EN
      , output err
`endif
   );

endinterface

// File: rtl/feature_store_writer_layer_phase_offset.sv
// rtl/feature_store_writer_layer_phase_offset.sv - layer/phase to RAM row base, shared with the fetch side
module feature_store_writer_layer_phase_offset
   import feature_store_writer_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int LAYER_STRIDE = LAYER_STRIDE_DEF,
   parameter int PHASE_STRIDE = PHASE_STRIDE_DEF
) (
   input  logic [3:0]        cs,
   input  logic [2:0]        phase,
   output logic [ADDR_W-1:0] base,
   output logic              valid
);

   layer_sel_t  sel;
   logic [31:0] sum;

   // Row base wraps modulo 2^ADDR_W; unknown codes land in region 0
   always_comb begin
      sel   = decode_layer(cs);
      sum   = 32'(sel.index) * 32'(LAYER_STRIDE) + 32'(phase) * 32'(PHASE_STRIDE);
      base  = sum[ADDR_W-1:0];
      valid = sel.valid;
   end

endmodule

// File: rtl/feature_store_writer.sv
// rtl/feature_store_writer.sv - splits a 36-word vector into 4 RAM beats at the layer/phase row base (optional FEATURE_STORE_ERR_EN)
module feature_store_writer
   import feature_store_writer_pkg::*;
#(
   parameter int DATA_LEN     = DATA_LEN_DEF,
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int LAYER_STRIDE = LAYER_STRIDE_DEF,
   parameter int PHASE_STRIDE = PHASE_STRIDE_DEF
) (
   input logic                   clk,
   input logic                   rst,
   feature_store_writer_if.slave bus
);

   localparam int BEAT_W = WORDS_PER_BEAT * DATA_LEN;
   localparam int VEC_W  = WORDS_PER_VEC * DATA_LEN;

   wr_state_t          state;
   logic [1:0]         beat;
   logic [1:0]         beat_nxt;
   logic [VEC_W-1:0]   d_cap;
   logic [ADDR_W-1:0]  base_q;
   logic [ADDR_W-1:0]  base;
   logic               code_ok;

   feature_store_writer_layer_phase_offset #(
      .ADDR_W       (ADDR_W),
      .LAYER_STRIDE (LAYER_STRIDE),
      .PHASE_STRIDE (PHASE_STRIDE)
   ) u_offset (
      .cs    (bus.cs),
      .phase (bus.phase),
      .base  (base),
      .valid (code_ok)
   );

`ifndef FEATURE_STORE_ERR_EN
   logic unused_code_ok;
   assign unused_code_ok = code_ok;
`endif

   assign beat_nxt = beat + 2'd1;

   // Capture on start, emit one beat per cycle, then a single done cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         beat         <= 2'd0;
         d_cap        <= '0;
         base_q       <= '0;
         bus.ready    <= 1'b1;
         bus.ram_we   <= 1'b0;
         bus.ram_addr <= '0;
         bus.ram_d    <= '0;
         bus.done     <= 1'b0;
`ifdef FEATURE_STORE_ERR_EN
         bus.err      <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  d_cap     <= bus.d;
                  base_q    <= base;
                  beat      <= 2'd0;
                  bus.ready <= 1'b0;
`ifdef FEATURE_STORE_ERR_EN
                  if (!code_ok) begin
                     state    <= ST_DONE;
                     bus.done <= 1'b1;
                     bus.err  <= 1'b1;
                  end else
`endif
                  begin
                     state        <= ST_WRITE;
                     bus.ram_we   <= 1'b1;
                     bus.ram_addr <= base;
                     bus.ram_d    <= bus.d[BEAT_W-1:0];
                  end
               end
            end
            ST_WRITE: begin
               if (beat == 2'd3) begin
                  state      <= ST_DONE;
                  bus.ram_we <= 1'b0;
                  bus.done   <= 1'b1;
               end else begin
                  beat         <= beat_nxt;
                  bus.ram_addr <= base_q + ADDR_W'(beat_nxt);
                  bus.ram_d    <= d_cap[int'(beat_nxt) * BEAT_W +: BEAT_W];
               end
            end
            ST_DONE: begin
               state     <= ST_IDLE;
               beat      <= 2'd0;
               bus.done  <= 1'b0;
               bus.ready <= 1'b1;
`ifdef FEATURE_STORE_ERR_EN
               bus.err   <= 1'b0;
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_feature_store_writer.sv
// tb/tb_feature_store_writer.sv - self-checking bench for feature_store_writer (honours FEATURE_STORE_ERR_EN)
module tb_feature_store_writer;
   import feature_store_writer_pkg::*;

   localparam int DL = DATA_LEN_DEF;
   localparam int AW = ADDR_W_DEF;
   localparam int BW = 9 * DL;
   localparam int VW = 36 * DL;

   logic clk = 1'b0;
   logic rst;

   feature_store_writer_if #(.DATA_LEN(DL), .ADDR_W(AW)) bus ();

   feature_store_writer #(.DATA_LEN(DL), .ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [BW-1:0] mem [0:255];

   // RAM model seen by the fetch side
   always @(negedge clk) begin
      if (bus.ram_we === 1'b1) mem[bus.ram_addr] = bus.ram_d;
   end

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic get_err();
`ifdef FEATURE_STORE_ERR_EN
      return bus.err;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit model_valid(input logic [3:0] c);
      return c <= 4'd4;
   endfunction

   function automatic logic [AW-1:0] model_base(input logic [3:0] c, input logic [2:0] p);
      int layer;
      int row;
      layer = model_valid(c) ? int'(c) : 0;
      row   = layer * 32 + int'(p) * 4;
      return AW'(row % (1 << AW));
   endfunction

   function automatic logic [VW-1:0] make_d(input int seed);
      logic [VW-1:0] v;
      for (int i = 0; i < 36; i++) v[i*DL +: DL] = DL'(i + 37 * seed);
      return v;
   endfunction

   function automatic logic [VW-1:0] rand_d();
      logic [VW-1:0] v;
      for (int i = 0; i < 36; i++) v[i*DL +: DL] = DL'($urandom);
      return v;
   endfunction

   task automatic run_txn(input string name, input logic [3:0] t_cs, input logic [2:0] t_ph,
                          input logic [VW-1:0] t_d, input logic [AW-1:0] exp_base, input bit disturb);
      logic [7:0]    we_m, done_m, ready_m, err_m;
      logic [7:0]    exp_we, exp_done, exp_ready, exp_err;
      logic [AW-1:0] waddr [$];
      logic [BW-1:0] wdata [$];
      logic [AW-1:0] hold_addr;
      bit            skip;
      we_m = 0; done_m = 0; ready_m = 0; err_m = 0;
      hold_addr = '0;
      skip = 1'b0;
`ifdef FEATURE_STORE_ERR_EN
      skip = !model_valid(t_cs);
`endif
      @(negedge clk);
      bus.start = 1'b1; bus.cs = t_cs; bus.phase = t_ph; bus.d = t_d;
      @(posedge clk);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         we_m[c]    = bus.ram_we;
         done_m[c]  = bus.done;
         ready_m[c] = bus.ready;
         err_m[c]   = get_err();
         if (bus.ram_we === 1'b1) begin
            waddr.push_back(bus.ram_addr);
            wdata.push_back(bus.ram_d);
         end
         if (c == 6) hold_addr = bus.ram_addr;
         if (c == 1) begin
            if (disturb) begin
               bus.d = ~t_d; bus.cs = t_cs ^ 4'h1; bus.phase = t_ph + 3'd1;
            end else begin
               bus.start = 1'b0;
            end
         end
         if (c == 4) bus.start = 1'b0;
      end
      exp_we    = skip ? 8'b0000_0000 : 8'b0001_1110;
      exp_done  = skip ? 8'b0000_0010 : 8'b0010_0000;
      exp_ready = skip ? 8'b1111_1100 : 8'b1100_0000;
      exp_err   = skip ? 8'b0000_0010 : 8'b0000_0000;
      check({name, "_we_pattern"}, VW'(we_m), VW'(exp_we));
      check({name, "_done_pattern"}, VW'(done_m), VW'(exp_done));
      check({name, "_ready_pattern"}, VW'(ready_m), VW'(exp_ready));
      check({name, "_err_pattern"}, VW'(err_m), VW'(exp_err));
      check({name, "_nwrites"}, VW'(waddr.size()), VW'(skip ? 0 : 4));
      for (int k = 0; k < waddr.size() && k < 4; k++) begin
         check($sformatf("%s_addr%0d", name, k), VW'(waddr[k]), VW'(exp_base + AW'(k)));
         check($sformatf("%s_data%0d", name, k), VW'(wdata[k]), VW'(t_d[k*BW +: BW]));
      end
      if (!skip) check({name, "_addr_hold"}, VW'(hold_addr), VW'(exp_base + AW'(3)));
   endtask

   typedef struct {
      string         name;
      logic [3:0]    cs;
      logic [2:0]    ph;
      logic [AW-1:0] base;
      bit            disturb;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int            bad;
      int            nacc;
      int            wcount;
      bit            saw_done;
      bit            idle;
      logic [VW-1:0] rb;

      vecs[0] = '{"basic_l1_p2",   LAYER1, 3'd2, 8'd40,  1'b0};
      vecs[1] = '{"affine_p7",     AFFINE, 3'd7, 8'd156, 1'b0};
      vecs[2] = '{"l0_p0",         LAYER0, 3'd0, 8'd0,   1'b0};
      vecs[3] = '{"l3_p7",         LAYER3, 3'd7, 8'd124, 1'b0};
      vecs[4] = '{"busy_l2_p5",    LAYER2, 3'd5, 8'd84,  1'b1};
      vecs[5] = '{"undef_f_p3",    4'hF,   3'd3, 8'd12,  1'b0};
      vecs[6] = '{"busy_l1_p2",    LAYER1, 3'd2, 8'd40,  1'b1};

      rst = 1'b1;
      bus.start = 1'b0; bus.cs = 4'd0; bus.phase = 3'd0; bus.d = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", VW'(bus.ready), VW'(1));
      check("rst_ram_we", VW'(bus.ram_we), VW'(0));
      check("rst_ram_addr", VW'(bus.ram_addr), VW'(0));
      check("rst_ram_d", VW'(bus.ram_d), VW'(0));
      check("rst_done", VW'(bus.done), VW'(0));
      check("rst_err", VW'(get_err()), VW'(0));
      rst = 1'b0;

      for (int i = 0; i < 7; i++)
         run_txn(vecs[i].name, vecs[i].cs, vecs[i].ph, make_d(i), vecs[i].base, vecs[i].disturb);

      rb = '0;
      for (int k = 0; k < 4; k++) rb[k*BW +: BW] = mem[156 + k];
      check("affine_readback", rb, make_d(1));

      // Reset sampled two edges after acceptance
      @(negedge clk);
      bus.start = 1'b1; bus.cs = LAYER3; bus.phase = 3'd1; bus.d = make_d(20);
      @(posedge clk);
      wcount = 0;
      saw_done = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (bus.ram_we === 1'b1) wcount++;
         if (bus.done === 1'b1) saw_done = 1'b1;
         if (c == 1) bus.start = 1'b0;
         if (c == 2) rst = 1'b1;
         if (c == 3) begin
            check("midrst_we_after", VW'(bus.ram_we), VW'(0));
            check("midrst_ready_after", VW'(bus.ready), VW'(1));
            rst = 1'b0;
         end
      end
      check("midrst_nwrites", VW'(wcount), VW'(2));
      check("midrst_no_done", VW'(saw_done), VW'(0));

      // Start held high: one transaction every 6 cycles
      @(negedge clk);
      bus.start = 1'b1; bus.cs = LAYER2; bus.phase = 3'd1; bus.d = make_d(9);
      @(posedge clk);
      bad = 0;
      nacc = 0;
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         if (bus.ram_we !== (((c - 1) % 6) < 4)) bad++;
         if (bus.done !== ((c % 6) == 5)) bad++;
         if (bus.ram_we === 1'b1 && ((c - 1) % 6) == 0 && bus.ram_addr === model_base(LAYER2, 3'd1)) nacc++;
      end
      bus.start = 1'b0;
      check("b2b_pattern_errs", VW'(bad), VW'(0));
      check("b2b_accepts", VW'(nacc), VW'(3));
      idle = 1'b0;
      for (int c = 0; c < 10 && !idle; c++) begin
         @(negedge clk);
         idle = (bus.ready === 1'b1);
      end
      check("b2b_back_to_idle", VW'(idle), VW'(1));

      for (int i = 0; i < 25; i++) begin
         logic [3:0] rc;
         logic [2:0] rp;
         bit         dis;
         rc  = ($urandom % 4 != 0) ? 4'($urandom % 5) : 4'($urandom_range(5, 15));
         rp  = 3'($urandom);
         dis = model_valid(rc) && ($urandom % 3 == 0);
         repeat ($urandom % 3) @(negedge clk);
         run_txn($sformatf("rnd%0d", i), rc, rp, rand_d(), model_base(rc, rp), dis);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
